// File: rtl/cgra_mport_bridge.sv
// cgra_mport_bridge: per-channel bridge between the CGRA master ports and the
// OBI-style system bus, plus the CGRA event-to-interrupt aggregator.
// Each channel has a one-entry request buffer, an outstanding-transaction
// limiter, a registered response stage and a sticky protocol-error flag.
// Channels are independent; all vectors are packed channel-major.
module cgra_mport_bridge #(
    parameter int N_MP      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 2,
    parameter int N_EVT     = 1
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    // CGRA side
    input  logic [N_MP-1:0]            cgra_req_i,
    input  logic [N_MP*ADDR_W-1:0]     cgra_add_i,
    input  logic [N_MP-1:0]            cgra_wen_i,
    input  logic [N_MP*DATA_W/8-1:0]   cgra_be_i,
    input  logic [N_MP*DATA_W-1:0]     cgra_wdata_i,
    output logic [N_MP-1:0]            cgra_gnt_o,
    output logic [N_MP-1:0]            cgra_r_valid_o,
    output logic [N_MP*DATA_W-1:0]     cgra_rdata_o,
    // Bus side
    output logic [N_MP-1:0]            bus_req_o,
    output logic [N_MP-1:0]            bus_we_o,
    output logic [N_MP*DATA_W/8-1:0]   bus_be_o,
    output logic [N_MP*ADDR_W-1:0]     bus_addr_o,
    output logic [N_MP*DATA_W-1:0]     bus_wdata_o,
    input  logic [N_MP-1:0]            bus_gnt_i,
    input  logic [N_MP-1:0]            bus_rvalid_i,
    input  logic [N_MP*DATA_W-1:0]     bus_rdata_i,
    // Protocol errors
    output logic [N_MP-1:0]            err_o,
    input  logic [N_MP-1:0]            err_clr_i,
    // Interrupts
    input  logic [N_EVT-1:0]           evt_i,
    input  logic [N_EVT-1:0]           irq_en_i,
    input  logic [N_EVT-1:0]           irq_clr_i,
    output logic [N_EVT-1:0]           irq_pending_o,
    output logic                       int_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // Per-channel request / response datapath
    // ------------------------------------------------------------------
    for (genvar c = 0; c < N_MP; c++) begin : g_ch

        logic              slot_v;
        logic [ADDR_W-1:0] slot_addr;
        logic              slot_we;
        logic [BE_W-1:0]   slot_be;
        logic [DATA_W-1:0] slot_wdata;
        logic [CNT_W-1:0]  cnt;
        logic [CNT_W-1:0]  cnt_next;
        logic              rsp_v;
        logic [DATA_W-1:0] rsp_data;
        logic              err;

        logic              req_ok;
        logic              bus_hs;
        logic              gnt;
        logic              capture;
        logic              rvalid;
        logic              err_set;

        // A buffered request may go out only while the channel is below its
        // outstanding limit; the slot can refill in the cycle it is handed off.
        assign rvalid  = bus_rvalid_i[c];
        assign req_ok  = slot_v && (cnt < CNT_MAX);
        assign bus_hs  = req_ok && bus_gnt_i[c];
        assign gnt     = !slot_v || bus_hs;
        assign capture = cgra_req_i[c] && gnt;

        // A response with nothing outstanding (and no handshake this cycle
        // that could account for it) is a protocol violation.
        assign err_set = rvalid && (cnt == '0) && !bus_hs;

        // Slot occupancy: filled on a CGRA handshake, emptied on a bus
        // handshake unless a new request refills it in the same cycle.
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                slot_v <= 1'b0;
            end else if (capture) begin
                slot_v <= 1'b1;
            end else if (bus_hs) begin
                slot_v <= 1'b0;
            end
        end

        // Slot payload only changes on capture, so the bus-side payload is
        // stable while a request waits for grant and holds when the slot is empty.
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                slot_addr  <= '0;
                slot_we    <= 1'b0;
                slot_be    <= '0;
                slot_wdata <= '0;
            end else if (capture) begin
                slot_addr  <= cgra_add_i[c*ADDR_W +: ADDR_W];
                slot_we    <= !cgra_wen_i[c];
                slot_be    <= cgra_be_i[c*BE_W +: BE_W];
                slot_wdata <= cgra_wdata_i[c*DATA_W +: DATA_W];
            end
        end

        // Outstanding count: up on handshake, down on response, unchanged when
        // both happen; a stray response at zero leaves it at zero.
        always_comb begin
            cnt_next = cnt;
            if (bus_hs && !rvalid) begin
                cnt_next = cnt + CNT_ONE;
            end else if (!bus_hs && rvalid && (cnt != '0)) begin
                cnt_next = cnt - CNT_ONE;
            end
        end

        // Outstanding count register.
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                cnt <= '0;
            end else begin
                cnt <= cnt_next;
            end
        end

        // Registered response stage; data holds between responses.
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                rsp_v    <= 1'b0;
                rsp_data <= '0;
            end else begin
                rsp_v <= rvalid;
                if (rvalid) begin
                    rsp_data <= bus_rdata_i[c*DATA_W +: DATA_W];
                end
            end
        end

        // Sticky protocol-error flag; a new error beats a simultaneous clear.
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                err <= 1'b0;
            end else if (err_set) begin
                err <= 1'b1;
            end else if (err_clr_i[c]) begin
                err <= 1'b0;
            end
        end

        assign cgra_gnt_o[c]                      = gnt;
        assign cgra_r_valid_o[c]                  = rsp_v;
        assign cgra_rdata_o[c*DATA_W +: DATA_W]   = rsp_data;
        assign bus_req_o[c]                       = req_ok;
        assign bus_we_o[c]                        = slot_we;
        assign bus_be_o[c*BE_W +: BE_W]           = slot_be;
        assign bus_addr_o[c*ADDR_W +: ADDR_W]     = slot_addr;
        assign bus_wdata_o[c*DATA_W +: DATA_W]    = slot_wdata;
        assign err_o[c]                           = err;
    end

    // ------------------------------------------------------------------
    // Interrupt aggregation
    // ------------------------------------------------------------------
    logic [N_EVT-1:0] evt_q;
    logic [N_EVT-1:0] pending;
    logic [N_EVT-1:0] evt_rise;

    assign evt_rise = evt_i & ~evt_q;

    // Delayed copy of the event lines for rising-edge detection.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_i;
        end
    end

    // Sticky pending bits; a rising edge beats a simultaneous clear.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~irq_clr_i) | evt_rise;
        end
    end

    assign irq_pending_o = pending;
    assign int_o         = |(pending & irq_en_i);

endmodule

// File: tb/tb_cgra_mport_bridge.sv
// tb_cgra_mport_bridge: directed, table-driven bench for cgra_mport_bridge.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
module tb_cgra_mport_bridge;

    localparam int N_MP      = 4;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MAX_OUTST = 2;
    localparam int N_EVT     = 2;
    localparam int BE_W      = DATA_W / 8;

    logic                     clk_i;
    logic                     rstn_i;
    logic [N_MP-1:0]          cgra_req_i;
    logic [N_MP*ADDR_W-1:0]   cgra_add_i;
    logic [N_MP-1:0]          cgra_wen_i;
    logic [N_MP*BE_W-1:0]     cgra_be_i;
    logic [N_MP*DATA_W-1:0]   cgra_wdata_i;
    logic [N_MP-1:0]          cgra_gnt_o;
    logic [N_MP-1:0]          cgra_r_valid_o;
    logic [N_MP*DATA_W-1:0]   cgra_rdata_o;
    logic [N_MP-1:0]          bus_req_o;
    logic [N_MP-1:0]          bus_we_o;
    logic [N_MP*BE_W-1:0]     bus_be_o;
    logic [N_MP*ADDR_W-1:0]   bus_addr_o;
    logic [N_MP*DATA_W-1:0]   bus_wdata_o;
    logic [N_MP-1:0]          bus_gnt_i;
    logic [N_MP-1:0]          bus_rvalid_i;
    logic [N_MP*DATA_W-1:0]   bus_rdata_i;
    logic [N_MP-1:0]          err_o;
    logic [N_MP-1:0]          err_clr_i;
    logic [N_EVT-1:0]         evt_i;
    logic [N_EVT-1:0]         irq_en_i;
    logic [N_EVT-1:0]         irq_clr_i;
    logic [N_EVT-1:0]         irq_pending_o;
    logic                     int_o;

    int compared   = 0;
    int mismatched = 0;

    cgra_mport_bridge #(
        .N_MP(N_MP), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MAX_OUTST(MAX_OUTST), .N_EVT(N_EVT)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .cgra_req_i(cgra_req_i), .cgra_add_i(cgra_add_i), .cgra_wen_i(cgra_wen_i),
        .cgra_be_i(cgra_be_i), .cgra_wdata_i(cgra_wdata_i),
        .cgra_gnt_o(cgra_gnt_o), .cgra_r_valid_o(cgra_r_valid_o), .cgra_rdata_o(cgra_rdata_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
        .err_o(err_o), .err_clr_i(err_clr_i),
        .evt_i(evt_i), .irq_en_i(irq_en_i), .irq_clr_i(irq_clr_i),
        .irq_pending_o(irq_pending_o), .int_o(int_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // One row = one cycle on channel 0: inputs, then expected outputs.
    typedef struct {
        logic        req;
        logic        wen;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        clr;
        logic        x_gnt;
        logic        x_req;
        logic        x_we;
        logic [31:0] x_addr;
        logic [31:0] x_wdata;
        logic [3:0]  x_be;
        logic        x_rv;
        logic [31:0] x_rdata;
        logic        x_err;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(
        input logic req, input logic wen, input logic [31:0] addr,
        input logic [3:0] be, input logic [31:0] wdata,
        input logic gnt, input logic rv, input logic [31:0] rdata, input logic clr,
        input logic x_gnt, input logic x_req, input logic x_we,
        input logic [31:0] x_addr, input logic [31:0] x_wdata, input logic [3:0] x_be,
        input logic x_rv, input logic [31:0] x_rdata, input logic x_err);
        vec_t v;
        v.req = req; v.wen = wen; v.addr = addr; v.be = be; v.wdata = wdata;
        v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.clr = clr;
        v.x_gnt = x_gnt; v.x_req = x_req; v.x_we = x_we; v.x_addr = x_addr;
        v.x_wdata = x_wdata; v.x_be = x_be; v.x_rv = x_rv; v.x_rdata = x_rdata;
        v.x_err = x_err;
        return v;
    endfunction

    // Compare one value and log a failure line if it differs.
    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one table row onto channel 0.
    task automatic applyStimulus(input vec_t v);
        cgra_req_i[0]         = v.req;
        cgra_wen_i[0]         = v.wen;
        cgra_add_i[31:0]      = v.addr;
        cgra_be_i[3:0]        = v.be;
        cgra_wdata_i[31:0]    = v.wdata;
        bus_gnt_i[0]          = v.gnt;
        bus_rvalid_i[0]       = v.rv;
        bus_rdata_i[31:0]     = v.rdata;
        err_clr_i[0]          = v.clr;
    endtask

    task automatic idleInputs();
        cgra_req_i   = '0;
        cgra_add_i   = '0;
        cgra_wen_i   = '1;
        cgra_be_i    = '0;
        cgra_wdata_i = '0;
        bus_gnt_i    = '0;
        bus_rvalid_i = '0;
        bus_rdata_i  = '0;
        err_clr_i    = '0;
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    // Everything zero except the CGRA grants.
    task automatic checkResetState(input string tag);
        checkOutput({tag, " cgra_gnt"}, cgra_gnt_o, 4'hF);
        checkOutput({tag, " r_valid"}, cgra_r_valid_o, 0);
        checkOutput({tag, " rdata"}, cgra_rdata_o, 0);
        checkOutput({tag, " bus_req"}, bus_req_o, 0);
        checkOutput({tag, " bus_we"}, bus_we_o, 0);
        checkOutput({tag, " bus_be"}, bus_be_o, 0);
        checkOutput({tag, " bus_addr"}, bus_addr_o, 0);
        checkOutput({tag, " bus_wdata"}, bus_wdata_o, 0);
        checkOutput({tag, " err"}, err_o, 0);
        checkOutput({tag, " pending"}, irq_pending_o, 0);
        checkOutput({tag, " int"}, int_o, 0);
    endtask

    initial begin
        // Channel 0 table: capture, stall, refill, outstanding limit,
        // simultaneous grant+response, stray response, error clear priority.
        vecs[0]  = mk(1,1,32'h40,4'hF,0,            0,0,0,0,           1,0,0,32'h40-32'h40,0,4'h0,0,0,0);
        vecs[1]  = mk(0,1,0,0,0,                    1,0,0,0,           1,1,0,32'h40,0,4'hF,0,0,0);
        vecs[2]  = mk(1,0,32'h44,4'h3,32'h11223344, 0,1,32'hAAAA0001,0, 1,0,0,32'h40,0,4'hF,0,0,0);
        vecs[3]  = mk(0,1,0,0,0,                    0,0,0,0,           0,1,1,32'h44,32'h11223344,4'h3,1,32'hAAAA0001,0);
        vecs[4]  = mk(1,1,32'h48,4'hF,0,            0,0,0,0,           0,1,1,32'h44,32'h11223344,4'h3,0,32'hAAAA0001,0);
        vecs[5]  = mk(1,1,32'h48,4'hF,0,            1,0,0,0,           1,1,1,32'h44,32'h11223344,4'h3,0,32'hAAAA0001,0);
        vecs[6]  = mk(0,1,0,0,0,                    1,0,0,0,           1,1,0,32'h48,0,4'hF,0,32'hAAAA0001,0);
        vecs[7]  = mk(1,1,32'h4C,4'hF,0,            1,0,0,0,           1,0,0,32'h48,0,4'hF,0,32'hAAAA0001,0);
        vecs[8]  = mk(0,1,0,0,0,                    1,0,0,0,           0,0,0,32'h4C,0,4'hF,0,32'hAAAA0001,0);
        vecs[9]  = mk(0,1,0,0,0,                    1,1,32'hBBBB0002,0, 0,0,0,32'h4C,0,4'hF,0,32'hAAAA0001,0);
        vecs[10] = mk(0,1,0,0,0,                    1,1,32'hCCCC0003,0, 1,1,0,32'h4C,0,4'hF,1,32'hBBBB0002,0);
        vecs[11] = mk(0,1,0,0,0,                    0,1,32'hDDDD0004,0, 1,0,0,32'h4C,0,4'hF,1,32'hCCCC0003,0);
        vecs[12] = mk(0,1,0,0,0,                    0,1,32'hEEEE0005,0, 1,0,0,32'h4C,0,4'hF,1,32'hDDDD0004,0);
        vecs[13] = mk(0,1,0,0,0,                    0,0,0,0,           1,0,0,32'h4C,0,4'hF,1,32'hEEEE0005,1);
        vecs[14] = mk(0,1,0,0,0,                    0,0,0,1,           1,0,0,32'h4C,0,4'hF,0,32'hEEEE0005,1);
        vecs[15] = mk(0,1,0,0,0,                    0,0,0,0,           1,0,0,32'h4C,0,4'hF,0,32'hEEEE0005,0);
        vecs[16] = mk(0,1,0,0,0,                    0,1,32'hFFFF0006,1, 1,0,0,32'h4C,0,4'hF,0,32'hEEEE0005,0);
        vecs[17] = mk(0,1,0,0,0,                    0,0,0,0,           1,0,0,32'h4C,0,4'hF,1,32'hFFFF0006,1);

        rstn_i    = 1'b0;
        evt_i     = '0;
        irq_en_i  = '0;
        irq_clr_i = '0;
        idleInputs();
        #2;
        checkResetState("reset");
        nextCycle();
        rstn_i = 1'b1;

        // ---------------- table-driven channel 0 ----------------
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk_i);
            checkOutput($sformatf("row%0d gnt", i),   cgra_gnt_o[0],        vecs[i].x_gnt);
            checkOutput($sformatf("row%0d req", i),   bus_req_o[0],         vecs[i].x_req);
            checkOutput($sformatf("row%0d we", i),    bus_we_o[0],          vecs[i].x_we);
            checkOutput($sformatf("row%0d addr", i),  bus_addr_o[31:0],     vecs[i].x_addr);
            checkOutput($sformatf("row%0d wdata", i), bus_wdata_o[31:0],    vecs[i].x_wdata);
            checkOutput($sformatf("row%0d be", i),    bus_be_o[3:0],        vecs[i].x_be);
            checkOutput($sformatf("row%0d rvalid", i),cgra_r_valid_o[0],    vecs[i].x_rv);
            checkOutput($sformatf("row%0d rdata", i), cgra_rdata_o[31:0],   vecs[i].x_rdata);
            checkOutput($sformatf("row%0d err", i),   err_o[0],             vecs[i].x_err);
            checkOutput($sformatf("row%0d others", i),bus_req_o[3:1],       0);
            nextCycle();
        end
        idleInputs();

        // ---------------- channel 2 streaming ----------------
        for (int t = 0; t < 12; t++) begin
            cgra_req_i[2]           = (t < 8);
            cgra_wen_i[2]           = 1'b1;
            cgra_add_i[64 +: 32]    = 32'h100 + 32'(4 * t);
            cgra_be_i[8 +: 4]       = 4'hF;
            bus_gnt_i[2]            = 1'b1;
            bus_rvalid_i[2]         = (t >= 2 && t <= 9);
            bus_rdata_i[64 +: 32]   = 32'hD000_0000 + 32'(t - 2);
            @(negedge clk_i);
            checkOutput($sformatf("stream t%0d gnt", t), cgra_gnt_o[2], 1);
            checkOutput($sformatf("stream t%0d req", t), bus_req_o[2], (t >= 1 && t <= 8));
            if (t >= 1 && t <= 8) begin
                checkOutput($sformatf("stream t%0d addr", t), bus_addr_o[64 +: 32],
                            32'h100 + 32'(4 * (t - 1)));
                checkOutput($sformatf("stream t%0d we", t), bus_we_o[2], 0);
            end
            checkOutput($sformatf("stream t%0d rvalid", t), cgra_r_valid_o[2], (t >= 3 && t <= 10));
            if (t >= 3 && t <= 10) begin
                checkOutput($sformatf("stream t%0d rdata", t), cgra_rdata_o[64 +: 32],
                            32'hD000_0000 + 32'(t - 3));
            end
            checkOutput($sformatf("stream t%0d xtalk req", t), bus_req_o & 4'b1011, 0);
            checkOutput($sformatf("stream t%0d xtalk rv", t), cgra_r_valid_o & 4'b1011, 0);
            nextCycle();
        end
        checkOutput("stream err", err_o[2], 0);
        idleInputs();

        // ---------------- channel 1 grant stall ----------------
        for (int s = 0; s < 11; s++) begin
            cgra_req_i[1]         = (s <= 6);
            cgra_wen_i[1]         = 1'b0;
            cgra_be_i[4 +: 4]     = 4'hF;
            cgra_add_i[32 +: 32]  = (s == 0) ? 32'h2000 : 32'h2004;
            cgra_wdata_i[32 +: 32]= (s == 0) ? 32'hDEADBEEF : 32'h12345678;
            bus_gnt_i[1]          = (s == 6 || s == 7);
            bus_rvalid_i[1]       = (s == 8 || s == 9);
            bus_rdata_i[32 +: 32] = 32'h0;
            @(negedge clk_i);
            if (s == 0) checkOutput("stall s0 gnt", cgra_gnt_o[1], 1);
            if (s >= 1 && s <= 6) begin
                checkOutput($sformatf("stall s%0d req", s),   bus_req_o[1], 1);
                checkOutput($sformatf("stall s%0d we", s),    bus_we_o[1], 1);
                checkOutput($sformatf("stall s%0d addr", s),  bus_addr_o[32 +: 32], 32'h2000);
                checkOutput($sformatf("stall s%0d wdata", s), bus_wdata_o[32 +: 32], 32'hDEADBEEF);
                checkOutput($sformatf("stall s%0d be", s),    bus_be_o[4 +: 4], 4'hF);
                checkOutput($sformatf("stall s%0d gnt", s),   cgra_gnt_o[1], (s == 6));
            end
            if (s == 7) begin
                checkOutput("stall s7 req", bus_req_o[1], 1);
                checkOutput("stall s7 addr", bus_addr_o[32 +: 32], 32'h2004);
                checkOutput("stall s7 wdata", bus_wdata_o[32 +: 32], 32'h12345678);
            end
            if (s == 8) checkOutput("stall s8 req", bus_req_o[1], 0);
            if (s == 9) checkOutput("stall s9 rvalid", cgra_r_valid_o[1], 1);
            if (s == 10) begin
                checkOutput("stall s10 rvalid", cgra_r_valid_o[1], 1);
                checkOutput("stall s10 err", err_o[1], 0);
            end
            nextCycle();
        end
        idleInputs();

        // ---------------- interrupts ----------------
        evt_i = 2'b01; irq_en_i = 2'b00;
        @(negedge clk_i);
        checkOutput("irq edge pending", irq_pending_o, 2'b00);
        nextCycle();
        @(negedge clk_i);
        checkOutput("irq set pending", irq_pending_o, 2'b01);
        checkOutput("irq set disabled int", int_o, 0);
        nextCycle();
        irq_en_i = 2'b01;
        @(negedge clk_i);
        checkOutput("irq enable int", int_o, 1);
        nextCycle();
        evt_i = 2'b00;
        nextCycle();
        evt_i = 2'b01; irq_clr_i = 2'b01;
        nextCycle();
        irq_clr_i = 2'b00;
        @(negedge clk_i);
        checkOutput("irq set beats clear", irq_pending_o, 2'b01);
        checkOutput("irq set beats clear int", int_o, 1);
        nextCycle();
        irq_clr_i = 2'b01;
        nextCycle();
        irq_clr_i = 2'b00;
        @(negedge clk_i);
        checkOutput("irq clear pending", irq_pending_o, 2'b00);
        checkOutput("irq clear int", int_o, 0);
        nextCycle();
        evt_i = 2'b11;
        nextCycle();
        @(negedge clk_i);
        checkOutput("irq ch1 pending", irq_pending_o, 2'b10);
        checkOutput("irq ch1 gated int", int_o, 0);
        nextCycle();
        irq_en_i = 2'b11;
        @(negedge clk_i);
        checkOutput("irq ch1 enabled int", int_o, 1);
        nextCycle();

        // ---------------- reset mid-burst on channel 3 ----------------
        cgra_req_i[3] = 1'b1; cgra_wen_i[3] = 1'b1;
        cgra_add_i[96 +: 32] = 32'h3000; cgra_be_i[12 +: 4] = 4'hF;
        bus_gnt_i[3] = 1'b1;
        nextCycle();
        cgra_add_i[96 +: 32] = 32'h3004;
        @(negedge clk_i);
        checkOutput("burst req", bus_req_o[3], 1);
        nextCycle();
        bus_rvalid_i[3] = 1'b1;
        bus_rdata_i[96 +: 32] = 32'h5555AAAA;
        @(negedge clk_i);
        #1;
        rstn_i = 1'b0;
        #1;
        checkResetState("midreset");
        idleInputs();
        nextCycle();
        rstn_i = 1'b1;
        bus_rvalid_i[3] = 1'b1;
        bus_rdata_i[96 +: 32] = 32'h0BAD0BAD;
        nextCycle();
        bus_rvalid_i[3] = 1'b0;
        @(negedge clk_i);
        checkOutput("post reset err", err_o, 4'b1000);
        checkOutput("post reset rvalid", cgra_r_valid_o, 4'b1000);
        checkOutput("post reset rdata", cgra_rdata_o[96 +: 32], 32'h0BAD0BAD);
        checkOutput("post reset req", bus_req_o, 0);
        nextCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cgra_mport_bridge.md
# cgra_mport_bridge

Parametrised bridge between the CGRA's N master ports (active-low write enable) and the system OBI-style data bus, together with the CGRA interrupt aggregator. It is the successor of the fixed four-port pass-through wrapper: the channel count and bus widths are parameters. It adds the following per channel:
- a one-entry request buffer;
- an outstanding-transaction limiter;
- a registered response stage;
- a sticky protocol-error flag.

Events become sticky, individually enabled and cleared interrupt pending bits. The block sits between `cgra_top` and the bus crossbar.

## Interface
Parameters:
- N_MP, 4: number of master channels (≥1).
- ADDR_W, 32: address width.
- DATA_W, 32: data width. Byte enable width is DATA_W/8.
- MAX_OUTST, 2: maximum granted-but-unanswered transactions per channel (1..15).
- N_EVT, 1: number of CGRA event lines.

Ports (vectors are packed and channel-major; channel c occupies slice c):
- clk_i, in, 1: clock. One clock domain.
- rstn_i, in, 1: asynchronous active-low reset.
- cgra_req_i, in, N_MP: CGRA request.
- cgra_add_i, in, N_MP*ADDR_W: CGRA address.
- cgra_wen_i, in, N_MP: write enable, active low (0 = write).
- cgra_be_i, in, N_MP*DATA_W/8: byte enables.
- cgra_wdata_i, in, N_MP*DATA_W: write data.
- cgra_gnt_o, out, N_MP: grant to CGRA.
- cgra_r_valid_o, out, N_MP: response valid to CGRA.
- cgra_rdata_o, out, N_MP*DATA_W: response data to CGRA.
- bus_req_o, out, N_MP: bus request.
- bus_we_o, out, N_MP: bus write enable, active high.
- bus_be_o, out, N_MP*DATA_W/8: bus byte enables.
- bus_addr_o, out, N_MP*ADDR_W: bus address.
- bus_wdata_o, out, N_MP*DATA_W: bus write data.
- bus_gnt_i, in, N_MP: bus grant.
- bus_rvalid_i, in, N_MP: bus response valid. One pulse per granted read or write.
- bus_rdata_i, in, N_MP*DATA_W: bus response data.
- err_o, out, N_MP: sticky per-channel protocol error.
- err_clr_i, in, N_MP: clears err_o.
- evt_i, in, N_EVT: CGRA event lines (level).
- irq_en_i, in, N_EVT: interrupt enables.
- irq_clr_i, in, N_EVT: pending-bit clear pulses.
- irq_pending_o, out, N_EVT: sticky pending bits.
- int_o, out, 1: merged interrupt.

## Operation
Channels are fully independent. Each channel holds the following state:
- slot: valid flag, addr, we, be, wdata.
- cnt: outstanding counter, width clog2(MAX_OUTST+1).
- registered response (valid, data).
- err flag.

Request path:
- cgra_gnt_o[c] = ~slot_v | bus_hs. Here bus_hs = bus_req_o[c] & bus_gnt_i[c]. Refill in the same cycle as the bus handshake gives full throughput.
- On cgra_req_i & cgra_gnt_o, the slot captures add, be, wdata, and we = ~wen, and slot_v ← 1.
- On bus_hs without a new capture, slot_v ← 0.
- bus_req_o[c] = slot_v & (cnt < MAX_OUTST). While a request is asserted and ungranted, its payload must not change and it must not drop. cnt can only decrease in that state, so this holds by construction.
- bus_addr_o, bus_we_o, bus_be_o and bus_wdata_o are driven from the slot. When slot_v=0 they keep their last values.

Outstanding counter:
- +1 on bus_hs; -1 on bus_rvalid_i.
- Both in the same cycle: unchanged.
- Never exceeds MAX_OUTST.

Response path:
- cgra_r_valid_o ← bus_rvalid_i and cgra_rdata_o ← bus_rdata_i, registered, for both reads and writes.
- cgra_rdata_o holds its value when there is no response.

Errors:
- bus_rvalid_i while cnt==0 and not bus_hs sets err. The counter stays 0; the response is still forwarded.
- err_clr_i clears err; a set in the same cycle wins.

Interrupts:
- evt_q holds evt_i delayed by one cycle.
- pending[i] is set on a rising edge (evt_i & ~evt_q) and cleared by irq_clr_i. Set wins over clear in the same cycle.
- int_o = |(pending & irq_en_i), combinational from registers.

Reset values (asynchronous, rstn_i=0): slot_v, cnt, err, the response registers, evt_q and pending are all 0. Therefore every output is 0 in reset, except cgra_gnt_o, which is 1. Reset asserted mid-transaction discards the slot and the count; responses that arrive after reset are flagged as errors.

## Timing
- CGRA grant: combinational, same cycle as cgra_req_i.
- CGRA handshake to bus_req_o: 1 cycle.
- bus_rvalid_i to cgra_r_valid_o: 1 cycle.
- Back-to-back: with bus_gnt_i held at 1 and cnt < MAX_OUTST, the channel sustains one request per cycle.
- Outstanding limit: when cnt==MAX_OUTST, bus_req_o is low. It rises the cycle after the bus_rvalid_i that drops cnt.
- Event edge to pending: 1 cycle. int_o follows pending in the same cycle, gated by irq_en_i.

## Test plan
1. **Reset:** rstn_i=0 mid-burst → all outputs 0 except cgra_gnt_o=1. After release, a stray bus_rvalid_i sets err_o.
2. **Streaming:** channel 2 issues 8 reads at addresses 0x100..0x11C, with bus_gnt_i=1 and rvalid 1 cycle after each grant. Expected:
   - bus_req_o[2] is continuous for 8 cycles, starting 1 cycle after the first cgra_req_i.
   - Data arrives in order, with each cgra_r_valid_o 1 cycle after its rvalid.
   - No cross-talk to other channels.
3. **Grant stall:** write of 0xDEADBEEF with be=0xF and wen=0, with bus_gnt_i held low for 5 cycles. Expected:
   - bus_req_o, bus_we_o=1, address and data stay stable for the 5 cycles.
   - cgra_gnt_o stays 0 until the bus grant.
4. **Outstanding limit (MAX_OUTST=2):** two grants with no rvalid → third bus_req_o held low. rvalid arrives → bus_req_o rises the next cycle. Simultaneous grant and rvalid → cnt unchanged.
5. **Interrupts:** evt_i[0] rises while irq_en_i=0 → pending=1, int_o=0. Setting irq_en_i=1 → int_o=1. irq_clr_i together with a new edge → pending stays 1. irq_clr_i alone → pending=0 and int_o=0.
